// File: rtl/cellram_wr_buffer_if.sv
// Wishbone classic bus between the CellRAM write buffer (master) and the
// CellRAM controller (slave).
interface cellram_wr_buffer_if;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_stb_o;
    logic        wbm_cyc_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/cellram_wr_buffer.sv
// Posted-write buffer in front of the CellRAM controller: writes are queued in a
// FIFO and drained as Wishbone classic cycles; reads wait until the FIFO is empty.
module cellram_wr_buffer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       cpu_req_i,
    input  logic                       cpu_we_i,
    input  logic [31:0]                cpu_adr_i,
    input  logic [31:0]                cpu_dat_i,
    input  logic [3:0]                 cpu_sel_i,
    output logic                       cpu_ready_o,
    output logic [31:0]                cpu_dat_o,
    output logic                       cpu_err_o,
    cellram_wr_buffer_if.master        wbm,
    output logic                       buf_empty_o,
    output logic                       wr_err_o
);
    localparam int unsigned    AW       = $clog2(DEPTH);
    localparam logic [AW:0]    CNT_FULL = DEPTH[AW:0];
    localparam logic [7:0]     TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

    state_t        r_state;
    logic [31:0]   r_fifo_adr [DEPTH];
    logic [31:0]   r_fifo_dat [DEPTH];
    logic [3:0]    r_fifo_sel [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_tmo;
    logic          r_rd_done;
    logic [31:0]   r_cpu_dat;
    logic          r_cpu_err;
    logic          r_wr_err;

    logic          w_full;
    logic          w_push;
    logic          w_tmo;
    logic          w_bus_err;
    logic          w_term;
    logic          w_pop;

    assign w_full    = (r_count == CNT_FULL);
    assign w_push    = cpu_req_i & cpu_we_i & ~w_full;
    // Timeout counter is cleared on entry, so the last allowed cycle is TIMEOUT-1.
    assign w_tmo     = (r_tmo == TMO_LAST);
    assign w_bus_err = wbm.wbm_err_i | w_tmo;
    assign w_term    = wbm.wbm_ack_i | w_bus_err;
    assign w_pop     = (r_state == ST_WRITE) & w_term;

    assign cpu_ready_o = w_push | r_rd_done;
    assign cpu_dat_o   = r_cpu_dat;
    assign cpu_err_o   = r_cpu_err;
    assign buf_empty_o = (r_count == '0) & (r_state == ST_IDLE);
    assign wr_err_o    = r_wr_err;

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_fifo_adr[r_wptr] <= cpu_adr_i;
            r_fifo_dat[r_wptr] <= cpu_dat_i;
            r_fifo_sel[r_wptr] <= cpu_sel_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= ST_IDLE;
            wbm.wbm_adr_o <= '0;
            wbm.wbm_dat_o <= '0;
            wbm.wbm_sel_o <= '0;
            wbm.wbm_we_o  <= 1'b0;
            wbm.wbm_stb_o <= 1'b0;
            wbm.wbm_cyc_o <= 1'b0;
            r_tmo         <= '0;
            r_rd_done     <= 1'b0;
            r_cpu_dat     <= '0;
            r_cpu_err     <= 1'b0;
            r_wr_err      <= 1'b0;
        end else begin
            r_rd_done <= 1'b0;
            r_tmo     <= r_tmo + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_tmo <= '0;
                    if (r_count != '0) begin
                        wbm.wbm_adr_o <= r_fifo_adr[r_rptr];
                        wbm.wbm_dat_o <= r_fifo_dat[r_rptr];
                        wbm.wbm_sel_o <= r_fifo_sel[r_rptr];
                        wbm.wbm_we_o  <= 1'b1;
                        wbm.wbm_stb_o <= 1'b1;
                        wbm.wbm_cyc_o <= 1'b1;
                        r_state       <= ST_WRITE;
                    end else if (cpu_req_i & ~cpu_we_i & ~r_rd_done) begin
                        wbm.wbm_adr_o <= cpu_adr_i;
                        wbm.wbm_sel_o <= cpu_sel_i;
                        wbm.wbm_we_o  <= 1'b0;
                        wbm.wbm_stb_o <= 1'b1;
                        wbm.wbm_cyc_o <= 1'b1;
                        r_state       <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (w_term) begin
                        wbm.wbm_stb_o <= 1'b0;
                        wbm.wbm_cyc_o <= 1'b0;
                        wbm.wbm_we_o  <= 1'b0;
                        if (w_bus_err) r_wr_err <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (w_term) begin
                        wbm.wbm_stb_o <= 1'b0;
                        wbm.wbm_cyc_o <= 1'b0;
                        r_cpu_dat     <= w_bus_err ? '0 : wbm.wbm_dat_i;
                        r_cpu_err     <= w_bus_err;
                        r_rd_done     <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cellram_wr_buffer.sv
// Randomized bench for cellram_wr_buffer: a Wishbone slave with memory, an
// expected bus-order queue and a word-level reference memory.
module tb_cellram_wr_buffer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;
    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_HANG = 2;
    localparam int M_BOTH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_adr = '0;
    logic [31:0] cpu_dat = '0;
    logic [3:0]  cpu_sel = '0;
    logic        cpu_ready;
    logic [31:0] cpu_rdat;
    logic        cpu_err;
    logic        buf_empty;
    logic        wr_err;

    cellram_wr_buffer_if wbs();

    cellram_wr_buffer #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_adr_i   (cpu_adr),
        .cpu_dat_i   (cpu_dat),
        .cpu_sel_i   (cpu_sel),
        .cpu_ready_o (cpu_ready),
        .cpu_dat_o   (cpu_rdat),
        .cpu_err_o   (cpu_err),
        .wbm         (wbs),
        .buf_empty_o (buf_empty),
        .wr_err_o    (wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          mode;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];
    logic        exp_wr_err = 1'b0;
    int          slv_rd_mode = M_ACK;
    logic [31:0] exp_rd_adr = '0;
    logic [3:0]  exp_rd_sel = '0;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    int unsigned late_ack_req = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{s[i]}};
        return (old & ~m) | (d & m);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
    endfunction

    // Wishbone slave: checks each cycle against the expected order, answers per mode.
    initial begin : slave
        int unsigned cnt;
        int unsigned lat;
        int          mode;
        logic        prev_resp;
        int unsigned late_done;
        wr_t         e;
        cnt = 0; lat = 1; mode = M_ACK; prev_resp = 1'b0; late_done = 0;
        e = '{adr: '0, dat: '0, sel: '0, mode: M_ACK};
        wbs.wbm_ack_i = 1'b0;
        wbs.wbm_err_i = 1'b0;
        wbs.wbm_dat_i = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wbs.wbm_ack_i = 1'b0;
                wbs.wbm_err_i = 1'b0;
                cnt = 0;
                prev_resp = 1'b0;
            end else if (prev_resp) begin
                chk("gap_stb", {31'd0, wbs.wbm_stb_o}, 32'd0);
                wbs.wbm_ack_i = 1'b0;
                wbs.wbm_err_i = 1'b0;
                prev_resp = 1'b0;
                cnt = 0;
            end else if (late_done != late_ack_req) begin
                late_done = late_ack_req;
                wbs.wbm_ack_i = 1'b1;
                prev_resp = 1'b1;
            end else if (wbs.wbm_stb_o) begin
                cnt++;
                if (cnt == 1) begin
                    chk("cyc_stb", {31'd0, wbs.wbm_cyc_o}, 32'd1);
                    lat = $urandom_range(lat_min, lat_max);
                    if (wbs.wbm_we_o) begin
                        if (exp_wr.size() == 0) begin
                            chk("unexp_wr", {31'd0, wbs.wbm_we_o}, 32'd0);
                            mode = M_HANG;
                        end else begin
                            e = exp_wr.pop_front();
                            chk("wr_adr", wbs.wbm_adr_o, e.adr);
                            chk("wr_dat", wbs.wbm_dat_o, e.dat);
                            chk("wr_sel", {28'd0, wbs.wbm_sel_o}, {28'd0, e.sel});
                            mode = e.mode;
                        end
                    end else begin
                        chk("rd_order", exp_wr.size(), 32'd0);
                        chk("rd_adr", wbs.wbm_adr_o, exp_rd_adr);
                        chk("rd_sel", {28'd0, wbs.wbm_sel_o}, {28'd0, exp_rd_sel});
                        mode = slv_rd_mode;
                    end
                end
                if (cnt >= lat && mode != M_HANG) begin
                    wbs.wbm_ack_i = (mode == M_ACK || mode == M_BOTH);
                    wbs.wbm_err_i = (mode == M_ERR || mode == M_BOTH);
                    if (wbs.wbm_we_o) begin
                        if (mode == M_ACK)
                            slv_mem[e.adr] = merge(slv_rd(e.adr), e.dat, e.sel);
                    end else begin
                        wbs.wbm_dat_i = (mode == M_ACK) ? slv_rd(wbs.wbm_adr_o) : $urandom;
                    end
                    prev_resp = 1'b1;
                end
            end else begin
                if (cnt > 0 && mode == M_HANG) chk("tmo_len", cnt, TMO);
                cnt = 0;
            end
        end
    end

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int m, output int unsigned waits);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = a; cpu_dat = d; cpu_sel = s;
        waits = 0;
        #1;
        while (!cpu_ready && waits < 400) begin
            @(posedge clk); #1;
            waits++;
        end
        chk("wr_accept", {31'd0, cpu_ready}, 32'd1);
        exp_wr.push_back('{adr: a, dat: d, sel: s, mode: m});
        if (m == M_ACK) ref_mem[a] = merge(ref_rd(a), d, s);
        else            exp_wr_err = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, input int m);
        int unsigned n;
        logic [31:0] e_dat;
        logic        e_err;
        n = 0;
        slv_rd_mode = m;
        exp_rd_adr  = a;
        exp_rd_sel  = 4'($urandom);
        e_dat = (m == M_ACK) ? ref_rd(a) : '0;
        e_err = (m != M_ACK);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = a; cpu_sel = exp_rd_sel; cpu_dat = $urandom;
        #1;
        while (!cpu_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rd_done", {31'd0, cpu_ready}, 32'd1);
        chk("rd_dat", cpu_rdat, e_dat);
        chk("rd_err", {31'd0, cpu_err}, {31'd0, e_err});
        @(posedge clk); #1;
        cpu_req = 1'b0;
        #1;
        chk("rd_pulse", {31'd0, cpu_ready}, 32'd0);
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (!buf_empty && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", {31'd0, buf_empty}, 32'd1);
        chk("wr_err", {31'd0, wr_err}, {31'd0, exp_wr_err});
    endtask

    task automatic idle_cycles(input int unsigned n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic int pick_mode();
        int unsigned r;
        r = $urandom_range(0, 19);
        case (r)
            0:       return M_ERR;
            1:       return M_HANG;
            2:       return M_BOTH;
            default: return M_ACK;
        endcase
    endfunction

    initial begin : main
        int unsigned w;
        int unsigned r;
        logic [31:0] a;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_cpu_dat", cpu_rdat, 32'd0);
        chk("rst_cpu_err", {31'd0, cpu_err}, 32'd0);
        chk("rst_adr", wbs.wbm_adr_o, 32'd0);
        chk("rst_dat", wbs.wbm_dat_o, 32'd0);
        chk("rst_ctl", {26'd0, wbs.wbm_sel_o, wbs.wbm_we_o, wbs.wbm_stb_o, wbs.wbm_cyc_o}, 32'd0);
        chk("rst_empty", {31'd0, buf_empty}, 32'd1);
        chk("rst_wr_err", {31'd0, wr_err}, 32'd0);
        rst = 1'b0;
        idle_cycles(1);

        // Single posted write and its bus timing.
        lat_min = 2; lat_max = 2;
        cpu_write(32'h100, 32'hDEADBEEF, 4'hF, M_ACK, w);
        chk("t1_wait", w, 32'd0);
        chk("t1_stb_e1", {31'd0, wbs.wbm_stb_o}, 32'd0);
        idle_cycles(1);
        chk("t1_stb_e2", {31'd0, wbs.wbm_stb_o}, 32'd1);
        chk("t1_we", {31'd0, wbs.wbm_we_o}, 32'd1);
        drain();

        // Six back-to-back writes into a 4-deep FIFO, slave acks 4 cycles after stb.
        lat_min = 4; lat_max = 4;
        for (int i = 0; i < 6; i++) begin
            cpu_write(32'h140 + 32'(i * 4), $urandom, 4'hF, M_ACK, w);
            if (i < 4)       chk("t2_accept", w, 32'd0);
            else if (i == 4) chk("t2_stall5", w, 32'd2);
        end
        drain();

        // Write then read-back of the same word.
        lat_min = 1; lat_max = 3;
        cpu_write(32'h200, 32'h12345678, 4'hF, M_ACK, w);
        cpu_read(32'h200, M_ACK);
        chk("t3_dat", cpu_rdat, 32'h12345678);

        // Read terminations: timeout, err, ack+err together.
        cpu_read(32'h204, M_HANG);
        cpu_read(32'h208, M_ERR);
        cpu_read(32'h20C, M_BOTH);
        drain();

        // Errored posted write sets a sticky flag.
        cpu_write(32'h300, 32'hCAFE0001, 4'hF, M_ERR, w);
        drain();
        for (int i = 0; i < 3; i++) begin
            cpu_write(32'h304 + 32'(i * 4), $urandom, 4'hF, M_ACK, w);
            drain();
        end
        cpu_read(32'h300, M_ACK);

        // Reset during a write with three more entries queued.
        for (int i = 0; i < 4; i++) cpu_write(32'h400 + 32'(i * 4), $urandom, 4'hF, M_HANG, w);
        chk("t6_busy", {31'd0, wbs.wbm_stb_o}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_stb", {31'd0, wbs.wbm_stb_o}, 32'd0);
        chk("t6_cyc", {31'd0, wbs.wbm_cyc_o}, 32'd0);
        chk("t6_empty", {31'd0, buf_empty}, 32'd1);
        chk("t6_wr_err", {31'd0, wr_err}, 32'd0);
        rst = 1'b0;
        exp_wr.delete();
        exp_wr_err = 1'b0;
        late_ack_req++;
        for (int i = 0; i < 3; i++) begin
            idle_cycles(1);
            chk("t6_late_stb", {31'd0, wbs.wbm_stb_o}, 32'd0);
            chk("t6_late_empty", {31'd0, buf_empty}, 32'd1);
        end

        // Randomized mix of writes and reads.
        lat_min = 1; lat_max = 5;
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 99);
            a = 32'h500 + 32'($urandom_range(0, 7) << 2);
            if (r < 65) cpu_write(a, $urandom, 4'($urandom_range(1, 15)), pick_mode(), w);
            else        cpu_read(a, pick_mode());
            idle_cycles($urandom_range(0, 2));
        end
        drain();
        for (int i = 0; i < 8; i++) cpu_read(32'h500 + 32'(i * 4), M_ACK);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end
endmodule
